// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage that sits after the ALU controller. It accepts a
//   load or store, runs a request/ready handshake with data memory, and
//   returns sign/zero-extended load data with a one-cycle done pulse.
//   The upstream pipeline is stalled while an access is outstanding.
//
// Parameters
//   TIMEOUT_CYCLES : ACCESS cycles allowed before aborting with err_timeout (>= 2)
//   ADDR_W         : byte address width
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   req_valid         : EX stage presents a memory instruction
//   MemRead/MemWrite  : load / store (store wins when both are set)
//   addr, wdata       : effective byte address, store source data
//   ReadDataSelect    : 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, others LW
//   WriteDataSelect   : 00 SW, 01 SB, 10 SH, 11 SW
//   mem_req/we/addr/be/wdata : registered request to data memory
//   mem_ready, mem_rdata     : memory completion and read word
//   rdata             : extended load result, held until the next load completes
//   done              : one-cycle completion pulse
//   stall             : combinational upstream freeze
//   err_timeout       : with done, access aborted after TIMEOUT_CYCLES
//   err_misalign      : with done, misaligned access trapped
//
// Build option
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned accesses skip memory and
//   complete immediately with err_misalign. When undefined, low address bits
//   below natural alignment are ignored and err_misalign stays 0.

module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [2:0]        ReadDataSelect,
  input  logic [1:0]        WriteDataSelect,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              err_timeout,
  output logic              err_misalign
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       alo_p1;
  logic [2:0]       rsel_p1;
  logic             accept;
  logic             timeout_hit;
  logic             misalign;

  function automatic logic [3:0] store_be(input logic [1:0] wsel, input logic [1:0] alo);
    case (wsel)
      2'b01:   store_be = 4'b0001 << alo;
      2'b10:   store_be = alo[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] wsel, input logic [31:0] wd);
    case (wsel)
      2'b01:   store_data = {4{wd[7:0]}};
      2'b10:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0]  rsel,
                                               input logic [1:0]  alo,
                                               input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{alo, 3'b000} +: 8];
    h = alo[1] ? word[31:16] : word[15:0];
    case (rsel)
      3'b001:  load_extract = 32'(b);
      3'b010:  load_extract = {24'b0, b};
      3'b011:  load_extract = 32'(h);
      3'b100:  load_extract = {16'b0, h};
      default: load_extract = word;
    endcase
  endfunction

  assign accept      = req_valid && (MemRead || MemWrite);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (MemWrite) begin
      case (WriteDataSelect)
        2'b01:   misalign = 1'b0;
        2'b10:   misalign = addr[0];
        default: misalign = (addr[1:0] != 2'b00);
      endcase
    end else begin
      case (ReadDataSelect)
        3'b001, 3'b010: misalign = 1'b0;
        3'b011, 3'b100: misalign = addr[0];
        default:        misalign = (addr[1:0] != 2'b00);
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  // Held low during reset so nothing upstream freezes on a dead unit.
  assign stall = !reset && (((state == IDLE) && accept) || (state == ACCESS));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = misalign ? RESP : ACCESS;
      ACCESS:  if (mem_ready || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: request capture and memory handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= 4'b0;
      mem_wdata    <= 32'b0;
      rdata        <= 32'b0;
      done         <= 1'b0;
      err_timeout  <= 1'b0;
      err_misalign <= 1'b0;
      cnt          <= '0;
    end else begin
      done         <= 1'b0;
      err_timeout  <= 1'b0;
      err_misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_we    <= MemWrite;
            mem_be    <= MemWrite ? store_be(WriteDataSelect, addr[1:0]) : 4'b1111;
            mem_wdata <= store_data(WriteDataSelect, wdata);
            cnt       <= '0;
            if (misalign) begin
              done         <= 1'b1;
              err_misalign <= 1'b1;
            end else begin
              mem_req <= 1'b1;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          // mem_ready takes priority over a timeout landing in the same cycle.
          if (mem_ready) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (!mem_we) rdata <= load_extract(rsel_p1, alo_p1, mem_rdata);
          end else if (timeout_hit) begin
            mem_req     <= 1'b0;
            done        <= 1'b1;
            err_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Lane/extension selectors are data: captured on accept, no reset needed.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && accept) begin
      alo_p1  <= addr[1:0];
      rsel_p1 <= ReadDataSelect;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, req_valid, MemRead, MemWrite;
  logic [31:0] addr, wdata;
  logic [2:0]  ReadDataSelect;
  logic [1:0]  WriteDataSelect;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata, rdata;
  logic        done, stall, err_timeout, err_misalign;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .MemRead(MemRead),
    .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
    .ReadDataSelect(ReadDataSelect), .WriteDataSelect(WriteDataSelect),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rdata(rdata), .done(done), .stall(stall), .err_timeout(err_timeout),
    .err_misalign(err_misalign)
  );

  typedef struct {
    bit          st;
    bit          both;
    logic [2:0]  rs;
    logic [1:0]  ws;
    logic [31:0] a, wd, mrd, e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    bit          to;
  } exp_t;

  exp_t        sbq[$];
  vec_t        tbl[15];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit st, bit both, logic [2:0] rs, logic [1:0] ws,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] mrd,
                              logic [31:0] e_addr, logic [3:0] e_be,
                              logic [31:0] e_wd, logic [31:0] e_rd);
    vec_t v;
    v.st = st; v.both = both; v.rs = rs; v.ws = ws; v.a = a; v.wd = wd;
    v.mrd = mrd; v.e_addr = e_addr; v.e_be = e_be; v.e_wd = e_wd; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_valid = 1'b1;
    MemWrite = v.st;
    MemRead = !v.st || v.both;
    addr = v.a;
    wdata = v.wd;
    ReadDataSelect = v.rs;
    WriteDataSelect = v.ws;
    mem_rdata = v.mrd;
  endtask

  task automatic idle_in();
    req_valid = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
  endtask

  // Called at posedge+1 with the unit idle. waits<0 means mem_ready never comes.
  task automatic do_access(input vec_t v, input int waits, input bit exp_to,
                           input int exp_cyc, input string nm);
    exp_t e;
    int   cyc;
    int   lat;
    bit   got;
    e.rd = (v.st || exp_to) ? last_rd : v.e_rd;
    e.to = exp_to;
    drive(v);
    #1 chk({nm, "_stall_T"}, {31'b0, stall}, 32'd1);
    sbq.push_back(e);
    @(posedge clk); #1;
    idle_in();
    cyc = 0; lat = 1; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (done) got = 1;
      else begin
        if (mem_req) begin
          chk({nm, "_addr"}, mem_addr, v.e_addr);
          chk({nm, "_be"}, {28'b0, mem_be}, {28'b0, v.e_be});
          chk({nm, "_we"}, {31'b0, mem_we}, {31'b0, v.st});
          chk({nm, "_stall_acc"}, {31'b0, stall}, 32'd1);
          if (v.st) chk({nm, "_wdata"}, mem_wdata, v.e_wd);
          mem_ready = (cyc == waits);
          cyc++;
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        lat++;
      end
    end
    if (!got) begin
      chk({nm, "_done_never"}, 32'd0, 32'd1);
      sbq.delete();
      return;
    end
    e = sbq.pop_front();
    chk({nm, "_rdata"}, rdata, e.rd);
    chk({nm, "_err_to"}, {31'b0, err_timeout}, {31'b0, e.to});
    chk({nm, "_err_mis"}, {31'b0, err_misalign}, 32'd0);
    chk({nm, "_stall_resp"}, {31'b0, stall}, 32'd0);
    chk({nm, "_req_resp"}, {31'b0, mem_req}, 32'd0);
    chk({nm, "_req_cycles"}, cyc, exp_cyc);
    chk({nm, "_latency"}, lat, exp_cyc + 1);
    last_rd = e.rd;
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, {31'b0, done}, 32'd0);
    chk({nm, "_err_clr"}, {31'b0, err_timeout}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset = 1'b1;
    idle_in();
    addr = 0; wdata = 0; ReadDataSelect = 0; WriteDataSelect = 0;
    mem_ready = 1'b0; mem_rdata = 0; last_rd = 0;

    //            st both rs     ws     addr    wdata         mrdata        e_addr  be       e_wdata       e_rdata
    tbl[0]  = mk(1, 0, 3'd0, 2'b00, 32'h104, 32'hDEADBEEF, 32'h0,        32'h104, 4'b1111, 32'hDEADBEEF, 32'h0);
    tbl[1]  = mk(1, 0, 3'd0, 2'b01, 32'h103, 32'h000000A5, 32'h0,        32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0);
    tbl[2]  = mk(1, 0, 3'd0, 2'b10, 32'h102, 32'h00001234, 32'h0,        32'h100, 4'b1100, 32'h12341234, 32'h0);
    tbl[3]  = mk(0, 0, 3'd1, 2'b00, 32'h201, 32'h0,        32'h000080FF, 32'h200, 4'b1111, 32'h0,        32'hFFFFFF80);
    tbl[4]  = mk(0, 0, 3'd2, 2'b00, 32'h201, 32'h0,        32'h000080FF, 32'h200, 4'b1111, 32'h0,        32'h00000080);
    tbl[5]  = mk(0, 0, 3'd3, 2'b00, 32'h202, 32'h0,        32'h80010000, 32'h200, 4'b1111, 32'h0,        32'hFFFF8001);
    tbl[6]  = mk(0, 0, 3'd4, 2'b00, 32'h202, 32'h0,        32'h80010000, 32'h200, 4'b1111, 32'h0,        32'h00008001);
    tbl[7]  = mk(0, 0, 3'd0, 2'b00, 32'h300, 32'h0,        32'h12345678, 32'h300, 4'b1111, 32'h0,        32'h12345678);
    tbl[8]  = mk(0, 0, 3'd7, 2'b00, 32'h304, 32'h0,        32'hCAFEF00D, 32'h304, 4'b1111, 32'h0,        32'hCAFEF00D);
    tbl[9]  = mk(1, 0, 3'd0, 2'b01, 32'h100, 32'h1234567F, 32'h0,        32'h100, 4'b0001, 32'h7F7F7F7F, 32'h0);
    tbl[10] = mk(1, 0, 3'd0, 2'b10, 32'h200, 32'hABCDBEEF, 32'h0,        32'h200, 4'b0011, 32'hBEEFBEEF, 32'h0);
    tbl[11] = mk(1, 0, 3'd0, 2'b11, 32'h020, 32'h11223344, 32'h0,        32'h020, 4'b1111, 32'h11223344, 32'h0);
    tbl[12] = mk(0, 0, 3'd1, 2'b00, 32'h003, 32'h0,        32'h7F000000, 32'h000, 4'b1111, 32'h0,        32'h0000007F);
    tbl[13] = mk(0, 0, 3'd3, 2'b00, 32'h000, 32'h0,        32'h0000FFFE, 32'h000, 4'b1111, 32'h0,        32'hFFFFFFFE);
    tbl[14] = mk(1, 1, 3'd1, 2'b00, 32'h040, 32'hCAFEBABE, 32'h55AA55AA, 32'h040, 4'b1111, 32'hCAFEBABE, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err_to", {31'b0, err_timeout}, 32'd0);
    chk("rst_err_mis", {31'b0, err_misalign}, 32'd0);
    req_valid = 1'b1; MemRead = 1'b1;
    #1 chk("rst_stall", {31'b0, stall}, 32'd0);
    idle_in();
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) do_access(tbl[i], 0, 1'b0, 1, $sformatf("v%0d", i));

    // Three wait states; ready lands on the timeout cycle and must win.
    v = mk(0, 0, 3'd3, 2'b00, 32'h202, 32'h0, 32'h80010000, 32'h200, 4'b1111, 32'h0, 32'hFFFF8001);
    do_access(v, 3, 1'b0, 4, "lh_wait3");

    // Memory never answers.
    v = mk(0, 0, 3'd0, 2'b00, 32'h400, 32'h0, 32'h55555555, 32'h400, 4'b1111, 32'h0, 32'h55555555);
    do_access(v, -1, 1'b1, TO, "tmo");

    // Next access after a timeout completes cleanly.
    v = mk(0, 0, 3'd0, 2'b00, 32'h404, 32'h0, 32'h0BADCAFE, 32'h404, 4'b1111, 32'h0, 32'h0BADCAFE);
    do_access(v, 1, 1'b0, 2, "after_tmo");

    // req_valid without MemRead/MemWrite is ignored.
    req_valid = 1'b1;
    #1 chk("noflag_stall", {31'b0, stall}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("noflag_req", {31'b0, mem_req}, 32'd0);
      chk("noflag_done", {31'b0, done}, 32'd0);
    end
    idle_in();

    // req_valid still high during RESP does not start another access.
    v = mk(0, 0, 3'd0, 2'b00, 32'h500, 32'h0, 32'h01020304, 32'h500, 4'b1111, 32'h0, 32'h01020304);
    drive(v);
    @(posedge clk); #1;
    chk("hold_req_access", {31'b0, mem_req}, 32'd1);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("hold_done", {31'b0, done}, 32'd1);
    chk("hold_rdata", rdata, 32'h01020304);
    chk("hold_stall_resp", {31'b0, stall}, 32'd0);
    last_rd = 32'h01020304;
    @(posedge clk); #1;
    chk("hold_idle_req", {31'b0, mem_req}, 32'd0);
    chk("hold_idle_done", {31'b0, done}, 32'd0);
    chk("hold_idle_stall", {31'b0, stall}, 32'd1);
    idle_in();
    #1 chk("hold_release_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of an access.
    v = mk(0, 0, 3'd0, 2'b00, 32'h600, 32'h0, 32'h77777777, 32'h600, 4'b1111, 32'h0, 32'h77777777);
    drive(v);
    @(posedge clk); #1;
    idle_in();
    chk("mid_rst_access", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    #1 chk("mid_rst_stall_now", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;
    last_rd = 32'h0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_done", {31'b0, done}, 32'd0);
      chk("post_rst_req", {31'b0, mem_req}, 32'd0);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    v = mk(0, 0, 3'd0, 2'b00, 32'h101, 32'h0, 32'hAABBCCDD, 32'h100, 4'b1111, 32'h0, 32'hAABBCCDD);
    drive(v);
    #1 chk("mis_stall_T", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    idle_in();
    chk("mis_done", {31'b0, done}, 32'd1);
    chk("mis_err", {31'b0, err_misalign}, 32'd1);
    chk("mis_req", {31'b0, mem_req}, 32'd0);
    chk("mis_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("mis_done_pulse", {31'b0, done}, 32'd0);
    chk("mis_req_after", {31'b0, mem_req}, 32'd0);
    chk("mis_err_clr", {31'b0, err_misalign}, 32'd0);
`else
    v = mk(0, 0, 3'd0, 2'b00, 32'h101, 32'h0, 32'hAABBCCDD, 32'h100, 4'b1111, 32'h0, 32'hAABBCCDD);
    do_access(v, 0, 1'b0, 1, "lw_unal");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
